// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with memory handshake and wait timeout.
// Define MULTICYCLE_JAL_EN to add the JAL state; otherwise op 1101111 decodes as Illegal.
module multicycle_controller #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       Illegal,
   output logic       Timeout
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
`ifdef MULTICYCLE_JAL_EN
      BEQ      = 4'd9,
      JAL      = 4'd10
`else
      BEQ      = 4'd9
`endif
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_flag;
   logic             wait_state;
   logic             expired;
   logic             pc_write_raw;
   logic             mem_write_raw;
   logic             ir_write_raw;
   logic             reg_write_raw;
   logic             illegal_raw;

   assign wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
   // A ready on the expiry cycle still counts as completion
   assign expired    = wait_state && !mem_ready && (wait_cnt == TO_VAL);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   // Wait counter clears on any state entry, including an aborted FETCH re-entering itself
   always_ff @(posedge clk) begin
      if (reset)                                   wait_cnt <= '0;
      else if ((next_state != state) || expired)   wait_cnt <= '0;
      else if (wait_state && !mem_ready)           wait_cnt <= wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      else                                         wait_cnt <= wait_cnt;
   end

   // Sticky timeout flag
   always_ff @(posedge clk) begin
      if (reset)        timeout_flag <= 1'b0;
      else if (expired) timeout_flag <= 1'b1;
      else              timeout_flag <= timeout_flag;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         FETCH:    next_state = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_R:         next_state = EXECR;
               OP_I:         next_state = EXECI;
               OP_BEQ:       next_state = BEQ;
`ifdef MULTICYCLE_JAL_EN
               OP_JAL:       next_state = JAL;
`endif
               default:      next_state = FETCH;
            endcase
         end
         MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  next_state = mem_ready ? MEMWB : (expired ? FETCH : MEMREAD);
         MEMWRITE: next_state = (mem_ready || expired) ? FETCH : MEMWRITE;
         MEMWB:    next_state = FETCH;
         EXECR:    next_state = ALUWB;
         EXECI:    next_state = ALUWB;
         ALUWB:    next_state = FETCH;
         BEQ:      next_state = FETCH;
`ifdef MULTICYCLE_JAL_EN
         JAL:      next_state = ALUWB;
`endif
         default:  next_state = FETCH;
      endcase
   end

   // Moore output decode, enables raw before reset/abort gating
   always_comb begin
      pc_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      AdrSrc        = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      ImmSrc        = 2'b00;
      case (state)
         FETCH: begin
            ir_write_raw = mem_ready;
            pc_write_raw = mem_ready;
            ALUSrcB      = 2'b10;
            ResultSrc    = 2'b10;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = 2'b10;
            case (op)
               OP_LW, OP_SW, OP_R, OP_I, OP_BEQ: illegal_raw = 1'b0;
`ifdef MULTICYCLE_JAL_EN
               OP_JAL:                           illegal_raw = 1'b0;
`endif
               default:                          illegal_raw = 1'b1;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = (op == OP_LW) ? 2'b00 : 2'b01;
         end
         MEMREAD:  AdrSrc = 1'b1;
         MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
         end
         MEMWB: begin
            ResultSrc     = 2'b01;
            reg_write_raw = 1'b1;
         end
         EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         ALUWB:    reg_write_raw = 1'b1;
         BEQ: begin
            ALUSrcA      = 2'b10;
            ALUOp        = 2'b01;
            pc_write_raw = Zero;
         end
`ifdef MULTICYCLE_JAL_EN
         JAL: begin
            ALUSrcA      = 2'b01;
            ALUSrcB      = 2'b10;
            pc_write_raw = 1'b1;
         end
`endif
         default:  illegal_raw = 1'b0;
      endcase
   end

   assign PCWrite  = pc_write_raw  & ~(reset | expired);
   assign IRWrite  = ir_write_raw  & ~(reset | expired);
   assign MemWrite = mem_write_raw & ~(reset | expired);
   assign RegWrite = reg_write_raw & ~reset;
   assign Illegal  = illegal_raw   & ~reset;
   assign Timeout  = timeout_flag;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output vectors queued by stimulus, popped by a monitor.
module tb_multicycle_controller;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,Illegal}
   localparam logic [15:0] F_GO    = {1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,2'b00,1'b0};
   localparam logic [15:0] F_WAIT  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,2'b00,1'b0};
   localparam logic [15:0] DEC     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b10,1'b0};
   localparam logic [15:0] DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,2'b10,1'b1};
   localparam logic [15:0] MA_LW   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,2'b00,1'b0};
   localparam logic [15:0] MA_SW   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,2'b01,1'b0};
   localparam logic [15:0] MR      = {1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0};
   localparam logic [15:0] MWR     = {1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0};
   localparam logic [15:0] MWB     = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,2'b00,1'b0};
   localparam logic [15:0] EXR     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,2'b00,1'b0};
   localparam logic [15:0] EXI     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,2'b00,1'b0};
   localparam logic [15:0] AWB     = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0};
   localparam logic [15:0] BEQ_T   = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,2'b00,1'b0};
   localparam logic [15:0] BEQ_F   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,2'b00,1'b0};
   localparam logic [15:0] JALV    = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,2'b00,1'b0};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, Timeout;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

   logic [16:0] exp_q[$];
   string       lbl_q[$];
   logic        exp_to = 1'b0;
   int          checks = 0;
   int          errors = 0;

   multicycle_controller #(.TIMEOUT(3), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal), .Timeout(Timeout)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are presented every cycle; compare at the falling edge
   always @(negedge clk) begin
      logic [16:0] got;
      logic [16:0] want;
      string       lbl;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         lbl  = lbl_q.pop_front();
         got  = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUOp, ImmSrc, Illegal, Timeout};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", lbl, got, want);
         end
      end
   end

   task automatic step(input string lbl, input logic [6:0] o, input logic z,
                       input logic mr, input logic rst, input logic [15:0] v);
      @(posedge clk);
      #1;
      op        = o;
      Zero      = z;
      mem_ready = mr;
      reset     = rst;
      exp_q.push_back({v, exp_to});
      lbl_q.push_back(lbl);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      step("reset_forces_writes_0", LW, 1'b0, 1'b1, 1'b1, F_WAIT);

      // lw, zero wait: 5 cycles, RegWrite only in the last
      step("lw_fetch",  LW, 1'b0, 1'b1, 1'b0, F_GO);
      step("lw_decode", LW, 1'b0, 1'b0, 1'b0, DEC);
      step("lw_memadr", LW, 1'b0, 1'b0, 1'b0, MA_LW);
      step("lw_memrd",  LW, 1'b0, 1'b1, 1'b0, MR);
      step("lw_memwb",  LW, 1'b0, 1'b1, 1'b0, MWB);

      // sw with 3 wait cycles; ready arrives exactly when counter hits TIMEOUT
      step("sw_fetch",  SW, 1'b0, 1'b1, 1'b0, F_GO);
      step("sw_decode", SW, 1'b0, 1'b1, 1'b0, DEC);
      step("sw_memadr", SW, 1'b0, 1'b1, 1'b0, MA_SW);
      for (int i = 0; i < 3; i++) step("sw_memwr_wait", SW, 1'b0, 1'b0, 1'b0, MWR);
      step("sw_memwr_done", SW, 1'b0, 1'b1, 1'b0, MWR);

      step("r_fetch_wait", RT, 1'b0, 1'b0, 1'b0, F_WAIT);
      step("r_fetch",      RT, 1'b0, 1'b1, 1'b0, F_GO);
      step("r_decode",     RT, 1'b0, 1'b1, 1'b0, DEC);
      step("r_exec",       RT, 1'b0, 1'b0, 1'b0, EXR);
      step("r_aluwb",      RT, 1'b0, 1'b0, 1'b0, AWB);

      step("i_fetch",  IT, 1'b0, 1'b1, 1'b0, F_GO);
      step("i_decode", IT, 1'b0, 1'b0, 1'b0, DEC);
      step("i_exec",   IT, 1'b0, 1'b0, 1'b0, EXI);
      step("i_aluwb",  IT, 1'b0, 1'b0, 1'b0, AWB);

      step("beq_t_fetch",  BQ, 1'b1, 1'b1, 1'b0, F_GO);
      step("beq_t_decode", BQ, 1'b1, 1'b0, 1'b0, DEC);
      step("beq_taken",    BQ, 1'b1, 1'b0, 1'b0, BEQ_T);
      step("beq_f_fetch",  BQ, 1'b0, 1'b1, 1'b0, F_GO);
      step("beq_f_decode", BQ, 1'b0, 1'b0, 1'b0, DEC);
      step("beq_not",      BQ, 1'b0, 1'b0, 1'b0, BEQ_F);

      step("ill_fetch",  BAD, 1'b0, 1'b1, 1'b0, F_GO);
      step("ill_decode", BAD, 1'b0, 1'b0, 1'b0, DEC_ILL);

      step("jal_fetch", JL, 1'b0, 1'b1, 1'b0, F_GO);
`ifdef MULTICYCLE_JAL_EN
      step("jal_decode", JL, 1'b0, 1'b0, 1'b0, DEC);
      step("jal_state",  JL, 1'b0, 1'b0, 1'b0, JALV);
      step("jal_aluwb",  JL, 1'b0, 1'b0, 1'b0, AWB);
`else
      step("jal_illegal", JL, 1'b0, 1'b0, 1'b0, DEC_ILL);
`endif

      // lw with two read wait cycles
      step("lw2_fetch",   LW, 1'b0, 1'b1, 1'b0, F_GO);
      step("lw2_decode",  LW, 1'b0, 1'b0, 1'b0, DEC);
      step("lw2_memadr",  LW, 1'b0, 1'b0, 1'b0, MA_LW);
      step("lw2_rd_wait", LW, 1'b0, 1'b0, 1'b0, MR);
      step("lw2_rd_wait", LW, 1'b0, 1'b0, 1'b0, MR);
      step("lw2_rd_done", LW, 1'b0, 1'b1, 1'b0, MR);
      step("lw2_memwb",   LW, 1'b0, 1'b0, 1'b0, MWB);

      // fetch timeout: three waits, abort on the fourth, flag visible after
      for (int i = 0; i < 4; i++) step("fetch_timeout_wait", RT, 1'b0, 1'b0, 1'b0, F_WAIT);
      exp_to = 1'b1;
      step("fetch_after_timeout", RT, 1'b0, 1'b0, 1'b0, F_WAIT);
      step("to_fetch",  SW, 1'b0, 1'b1, 1'b0, F_GO);
      step("to_decode", SW, 1'b0, 1'b0, 1'b0, DEC);
      step("to_memadr", SW, 1'b0, 1'b0, 1'b0, MA_SW);
      for (int i = 0; i < 3; i++) step("sw_to_wait", SW, 1'b0, 1'b0, 1'b0, MWR);
      step("sw_to_abort_no_write", SW, 1'b0, 1'b0, 1'b0, MR);
      step("sw_to_back_fetch",     SW, 1'b0, 1'b0, 1'b0, F_WAIT);

      // reset while in MEMWRITE
      step("rs_fetch",  SW, 1'b0, 1'b1, 1'b0, F_GO);
      step("rs_decode", SW, 1'b0, 1'b0, 1'b0, DEC);
      step("rs_memadr", SW, 1'b0, 1'b0, 1'b0, MA_SW);
      step("rs_memwr",  SW, 1'b0, 1'b0, 1'b0, MWR);
      step("rs_reset_in_memwr", SW, 1'b0, 1'b1, 1'b1, MR);
      exp_to = 1'b0;
      step("rs_after_reset", SW, 1'b0, 1'b0, 1'b0, F_WAIT);
      step("rs_fetch_again", SW, 1'b0, 1'b1, 1'b0, F_GO);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
